div_seq: RTL and testbench



---
 rtl/div_seq.sv | 138 +++++++++++++
 tb/tb_div_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: iterative unsigned restoring divider. One trial subtraction per
// clock; start/busy/done handshake toward the ALU operation decoder.
module div_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] input_1,
   input  logic [WIDTH-1:0] input_2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   // Working registers: D doubles as the quotient shift register.
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] v_reg;
   logic [WIDTH-1:0] r_reg;
   logic [CW-1:0]    cnt_reg;

   logic [WIDTH-1:0] quotient_reg;
   logic [WIDTH-1:0] remainder_reg;
   logic             div_zero_reg;

   logic [WIDTH:0]   trial_t;
   logic [WIDTH:0]   trial_s;
   logic             borrow;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] d_next;
   logic             last_iter;

   // Trial subtraction for the current iteration; the top bit of S is the borrow.
   always_comb begin
      trial_t   = {r_reg, d_reg[WIDTH-1]};
      trial_s   = trial_t - {1'b0, v_reg};
      borrow    = trial_s[WIDTH];
      r_next    = borrow ? trial_t[WIDTH-1:0] : trial_s[WIDTH-1:0];
      d_next    = {d_reg[WIDTH-2:0], ~borrow};
      last_iter = (cnt_reg == CW'(1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; a zero divisor skips CALC entirely.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = (input_2 != '0) ? CALC : DONE;
            end
         end
         CALC: begin
            if (last_iter) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         CALC:    busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Operand capture, iteration datapath and result registers loaded on DONE entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_reg         <= '0;
         v_reg         <= '0;
         r_reg         <= '0;
         cnt_reg       <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         div_zero_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  d_reg   <= input_1;
                  v_reg   <= input_2;
                  r_reg   <= '0;
                  cnt_reg <= CW'(WIDTH);
                  if (input_2 == '0) begin
                     quotient_reg  <= '1;
                     remainder_reg <= input_1;
                     div_zero_reg  <= 1'b1;
                  end
               end
            end
            CALC: begin
               d_reg   <= d_next;
               r_reg   <= r_next;
               cnt_reg <= cnt_reg - CW'(1);
               if (last_iter) begin
                  quotient_reg  <= d_next;
                  remainder_reg <= r_next;
                  div_zero_reg  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign quotient  = quotient_reg;
   assign remainder = remainder_reg;
   assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: table-driven directed vectors plus hand-written multi-cycle
// sequences for the divider handshake corners.
module tb_div_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] input_1;
   logic [7:0] input_2;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_zero;

   int checks = 0;
   int errors = 0;

   div_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .input_1   (input_1),
      .input_2   (input_2),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
   } vec_t;

   vec_t vecs [7];

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue one single-cycle start and watch 12 post-accept samples.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input bit quiet);
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_at = -1;
      input_1 = a;
      input_2 = b;
      start = 1'b1;
      step();
      start = 1'b0;
      input_1 = ~a;
      input_2 = 8'h55;
      for (int s = 0; s < 12; s++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = s;
         end
         if (s < 11) step();
      end
      chk("busy_cycles", busy_cnt, (b == 0) ? 0 : 8);
      chk("done_count", done_cnt, 1);
      chk("done_latency", done_at, (b == 0) ? 0 : 8);
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      chk("div_zero", div_zero, edz);
      if (!quiet)
         $display("op %0d/%0d: q=%0d r=%0d dz=%0d busy=%0d done=%0d@%0d",
                  a, b, quotient, remainder, div_zero, busy_cnt, done_cnt, done_at);
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_q"}, quotient, 0);
      chk({tag, "_r"}, remainder, 0);
      chk({tag, "_dz"}, div_zero, 0);
   endtask

   initial begin
      int done_cnt;
      int busy_cnt;
      int last_done;
      logic [7:0] a;
      logic [7:0] b;

      vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
      vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
      vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
      vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
      vecs[4] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
      vecs[5] = '{8'd100, 8'd0,   8'd255, 8'd100, 1'b1};
      vecs[6] = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0};

      rst = 1'b1;
      start = 1'b0;
      input_1 = 8'd0;
      input_2 = 8'd0;
      step();
      step();
      rst = 1'b0;
      chk_idle_zero("reset");
      $display("reset: busy=%0d done=%0d q=%0d r=%0d dz=%0d",
               busy, done, quotient, remainder, div_zero);

      // Directed table, including zero path followed by a clearing result.
      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0);
      end

      // start pulsed mid-CALC with new operands must be ignored.
      input_1 = 8'd50;
      input_2 = 8'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      done_cnt = 0;
      busy_cnt = 0;
      for (int s = 0; s < 20; s++) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (s == 2) begin
            input_1 = 8'd9;
            input_2 = 8'd9;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         step();
      end
      chk("ignore_done_count", done_cnt, 1);
      chk("ignore_busy_cycles", busy_cnt, 8);
      chk("ignore_q", quotient, 10);
      chk("ignore_r", remainder, 0);
      $display("ignore-start 50/5: q=%0d r=%0d busy=%0d done=%0d",
               quotient, remainder, busy_cnt, done_cnt);

      // Reset mid-CALC aborts without a done pulse.
      input_1 = 8'd200;
      input_2 = 8'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle_zero("abort");
      done_cnt = 0;
      for (int s = 0; s < 10; s++) begin
         if (done || busy) done_cnt++;
         step();
      end
      chk("abort_quiet", done_cnt, 0);
      $display("abort 200/7: busy=%0d done=%0d q=%0d r=%0d activity=%0d",
               busy, done, quotient, remainder, done_cnt);
      run_op(8'd13, 8'd4, 8'd3, 8'd1, 1'b0, 1'b0);

      // start held high: one result every WIDTH+2 cycles.
      input_1 = 8'd77;
      input_2 = 8'd6;
      start = 1'b1;
      step();
      done_cnt = 0;
      last_done = -1;
      for (int s = 0; s < 32; s++) begin
         if (done) begin
            done_cnt++;
            chk("held_q", quotient, 12);
            chk("held_r", remainder, 5);
            if (last_done >= 0) chk("held_interval", s - last_done, 10);
            else chk("held_first", s, 8);
            last_done = s;
         end
         step();
      end
      start = 1'b0;
      chk("held_done_count", done_cnt, 3);
      $display("held-start 77/6: pulses=%0d q=%0d r=%0d", done_cnt, quotient, remainder);
      for (int s = 0; s < 12; s++) step();

      // Random operand sweep checked against the arithmetic definition.
      for (int i = 0; i < 300; i++) begin
         a = 8'($urandom_range(0, 255));
         b = (i % 25 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         if (b == 0) run_op(a, b, 8'hFF, a, 1'b1, 1'b1);
         else        run_op(a, b, a / b, a % b, 1'b0, 1'b1);
      end
      $display("random sweep: 300 operations");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
